// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port framebuffer RAM between the VGA pixel
// fetch and a CPU port. The framebuffer is 160x120 bytes (RRRGGGBB), each
// byte covering a 4x4 block of screen pixels.
//
// Every active-region cycle with x_pos[1:0] == 0 is a display slot: the RAM
// is addressed with the pixel block and the returned byte is loaded into the
// pixel register one cycle later. All other cycles are CPU slots, so a CPU
// request waits at most one cycle.
//
// Ports
//   clk_25M, rst                  pixel clock, synchronous active-high reset
//   x_pos, y_pos                  raster position from the VGA timing block
//   cpu_req/we/addr/wdata         CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_err              grant pulse, out-of-range address flag
//   cpu_rdata, cpu_rvalid         read response, one cycle after the grant
//   ram_addr/we/wdata, ram_rdata  single-port RAM, one-cycle read latency
//   redOut, greenOut, blueOut     pixel colour to the VGA timing block
//
// Build option
//   FB_CPU_READ_EN  when defined, CPU reads return data. When undefined, reads
//                   are granted as no-ops and cpu_rvalid/cpu_rdata stay 0.
module fb_arbiter (
  input  logic        clk_25M,
  input  logic        rst,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_err,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [2:0]  redOut,
  output logic [2:0]  greenOut,
  output logic [1:0]  blueOut
);

  localparam logic [14:0] FB_WORDS = 15'd19200;

  logic        active;
  logic        disp_slot;
  logic [14:0] row_base;
  logic [14:0] disp_addr;
  logic        rd_issue;

  logic [14:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic [7:0]  pix_q;
  logic        rd_pend_q;
  logic        rd_err_q;
  logic        fetch_q;

  assign active    = (x_pos < 10'd640) && (y_pos < 10'd480);
  assign disp_slot = active && (x_pos[1:0] == 2'b00);
  assign row_base  = {8'd0, y_pos[8:2]} * 15'd160;
  assign disp_addr = row_base + {7'd0, x_pos[9:2]};

`ifdef FB_CPU_READ_EN
  assign rd_issue = cpu_gnt && !cpu_we;
`else
  assign rd_issue = 1'b0;
`endif

  // Outputs are forced to zero while rst is high so that reset is visible in
  // the same cycle, not only after the next edge.
  always_comb begin
    cpu_gnt    = 1'b0;
    cpu_err    = 1'b0;
    cpu_rvalid = 1'b0;
    cpu_rdata  = 8'h00;
    ram_addr   = 15'd0;
    ram_we     = 1'b0;
    ram_wdata  = 8'h00;
    redOut     = 3'd0;
    greenOut   = 3'd0;
    blueOut    = 2'd0;
    if (!rst) begin
      cpu_gnt  = cpu_req && !disp_slot;
      cpu_err  = cpu_gnt && (cpu_addr >= FB_WORDS);
      ram_we   = cpu_gnt && cpu_we && !cpu_err;
      if (disp_slot)
        ram_addr = disp_addr;
      else if (cpu_gnt)
        ram_addr = cpu_addr;
      else
        ram_addr = addr_q;
      ram_wdata  = (cpu_gnt && cpu_we) ? cpu_wdata : wdata_q;
      cpu_rvalid = rd_pend_q;
      if (rd_pend_q)
        cpu_rdata = rd_err_q ? 8'h00 : ram_rdata;
      else
        cpu_rdata = rdata_q;
      // Gating by the active region keeps the last fetched pixel of a line
      // from leaking into the blanking interval.
      if (active) begin
        redOut   = pix_q[7:5];
        greenOut = pix_q[4:2];
        blueOut  = pix_q[1:0];
      end
    end
  end

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      addr_q    <= 15'd0;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      pix_q     <= 8'h00;
      rd_pend_q <= 1'b0;
      rd_err_q  <= 1'b0;
      fetch_q   <= 1'b0;
    end else begin
      addr_q    <= ram_addr;
      if (cpu_gnt && cpu_we)
        wdata_q <= cpu_wdata;
      if (cpu_rvalid)
        rdata_q <= cpu_rdata;
      rd_pend_q <= rd_issue;
      rd_err_q  <= cpu_err;
      fetch_q   <= disp_slot;
      if (fetch_q)
        pix_q <= active ? ram_rdata : 8'h00;
    end
  end

  // A read response needs a CPU slot in the previous cycle, a pixel load
  // needs a display slot there, so the two can never coincide.
  assert property (@(posedge clk_25M) disable iff (rst) !(rd_pend_q && fetch_q));

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

  logic        clk_25M;
  logic        rst;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_err;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [2:0]  redOut;
  logic [2:0]  greenOut;
  logic [1:0]  blueOut;

`ifdef FB_CPU_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  fb_arbiter dut (
    .clk_25M   (clk_25M),
    .rst       (rst),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .redOut    (redOut),
    .greenOut  (greenOut),
    .blueOut   (blueOut)
  );

  initial begin
    clk_25M = 1'b0;
    forever #20 clk_25M = ~clk_25M;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: what the arbiter owes the outside world, cycle by cycle.
  // It remembers the last RAM address, write data and read data seen on the
  // pins, whether a read answer or a pixel byte is due next cycle, and the
  // pixel currently being shown.
  logic [14:0] m_addr       = '0;
  logic [7:0]  m_wdata      = '0;
  logic [7:0]  m_rdata      = '0;
  logic [7:0]  m_pix        = '0;
  bit          m_answer_due = 1'b0;
  bit          m_answer_zero= 1'b0;
  bit          m_pixel_due  = 1'b0;

  task automatic model_cycle();
    int xi, yi;
    bit act, slot, gnt, err, wr, rv;
    logic [14:0] e_addr;
    logic [7:0]  e_wdata, e_rdata, e_pix;
    xi   = int'(x_pos);
    yi   = int'(y_pos);
    act  = (xi < 640) && (yi < 480);
    slot = act && (xi % 4 == 0);
    if (rst) begin
      gnt = 0; err = 0; wr = 0; rv = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0; e_pix = '0;
    end else begin
      gnt = cpu_req && !slot;
      err = gnt && (int'(cpu_addr) >= 19200);
      wr  = gnt && cpu_we && !err;
      if (slot)     e_addr = 15'((yi / 4) * 160 + xi / 4);
      else if (gnt) e_addr = cpu_addr;
      else          e_addr = m_addr;
      e_wdata = (gnt && cpu_we) ? cpu_wdata : m_wdata;
      rv      = m_answer_due;
      e_rdata = rv ? (m_answer_zero ? 8'h00 : ram_rdata) : m_rdata;
      e_pix   = act ? m_pix : 8'h00;
    end
    chk("m_gnt",    32'(cpu_gnt),    32'(gnt));
    chk("m_err",    32'(cpu_err),    32'(err));
    chk("m_ram_we", 32'(ram_we),     32'(wr));
    chk("m_addr",   32'(ram_addr),   32'(e_addr));
    chk("m_wdata",  32'(ram_wdata),  32'(e_wdata));
    chk("m_rvalid", 32'(cpu_rvalid), 32'(rv));
    chk("m_rdata",  32'(cpu_rdata),  32'(e_rdata));
    chk("m_colour", 32'({redOut, greenOut, blueOut}), 32'(e_pix));
    if (rst) begin
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_pix = '0;
      m_answer_due = 0; m_answer_zero = 0; m_pixel_due = 0;
    end else begin
      m_addr  = e_addr;
      m_wdata = e_wdata;
      m_rdata = e_rdata;
      if (m_pixel_due) m_pix = act ? ram_rdata : 8'h00;
      m_pixel_due   = slot;
      m_answer_due  = READ_EN && gnt && !cpu_we;
      m_answer_zero = err;
    end
  endtask

  always @(negedge clk_25M) model_cycle();

  typedef struct {
    logic        rst;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        req;
    logic        we;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic        e_gnt;
    logic        e_err;
    logic        e_we;
    logic [14:0] e_addr;
  } vec_t;

  vec_t vecs[14];

  task automatic drive(input logic r, input int x, input int y, input logic req,
                       input logic we, input int addr, input logic [7:0] wd,
                       input logic [7:0] rd);
    rst = r; x_pos = 10'(x); y_pos = 10'(y);
    cpu_req = req; cpu_we = we; cpu_addr = 15'(addr); cpu_wdata = wd;
    ram_rdata = rd;
  endtask

  task automatic to_sample();
    @(negedge clk_25M);
  endtask

  task automatic to_drive();
    @(posedge clk_25M);
    #1;
  endtask

  initial begin
    int xi, yi;
    bit seen_gnt;
    drive(1'b1, 0, 500, 1'b0, 1'b0, 0, 8'h00, 8'h00);

    vecs[0]  = '{1'b1,  10'd0, 10'd500, 1'b1, 1'b1, 15'd5,     8'hE3, 1'b0, 1'b0, 1'b0, 15'd0};
    vecs[1]  = '{1'b0,  10'd0, 10'd500, 1'b1, 1'b1, 15'd5,     8'hE3, 1'b1, 1'b0, 1'b1, 15'd5};
    vecs[2]  = '{1'b0,  10'd1, 10'd500, 1'b0, 1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 15'd5};
    vecs[3]  = '{1'b0,  10'd4, 10'd8,   1'b0, 1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 15'd321};
    vecs[4]  = '{1'b0,  10'd5, 10'd8,   1'b0, 1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 15'd321};
    vecs[5]  = '{1'b0,  10'd12, 10'd8,  1'b1, 1'b1, 15'd100,   8'h11, 1'b0, 1'b0, 1'b0, 15'd323};
    vecs[6]  = '{1'b0,  10'd13, 10'd8,  1'b1, 1'b1, 15'd100,   8'h11, 1'b1, 1'b0, 1'b1, 15'd100};
    vecs[7]  = '{1'b0,  10'd14, 10'd8,  1'b0, 1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 15'd100};
    vecs[8]  = '{1'b0,  10'd0, 10'd500, 1'b1, 1'b1, 15'd19200, 8'h22, 1'b1, 1'b1, 1'b0, 15'd19200};
    vecs[9]  = '{1'b0,  10'd1, 10'd500, 1'b1, 1'b1, 15'd32767, 8'h33, 1'b1, 1'b1, 1'b0, 15'd32767};
    vecs[10] = '{1'b0, 10'd639, 10'd479, 1'b1, 1'b1, 15'd0,    8'h44, 1'b1, 1'b0, 1'b1, 15'd0};
    vecs[11] = '{1'b0, 10'd636, 10'd479, 1'b1, 1'b1, 15'd7,    8'h55, 1'b0, 1'b0, 1'b0, 15'd19199};
    vecs[12] = '{1'b0, 10'd640, 10'd0,   1'b1, 1'b1, 15'd7,    8'h55, 1'b1, 1'b0, 1'b1, 15'd7};
    vecs[13] = '{1'b0,  10'd0, 10'd480,  1'b0, 1'b0, 15'd0,    8'h00, 1'b0, 1'b0, 1'b0, 15'd7};

    to_drive();
    to_drive();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, int'(vecs[i].x), int'(vecs[i].y), vecs[i].req, vecs[i].we,
            int'(vecs[i].addr), vecs[i].wdata, 8'h5A);
      to_sample();
      chk($sformatf("v%0d_gnt", i),  32'(cpu_gnt),  32'(vecs[i].e_gnt));
      chk($sformatf("v%0d_err", i),  32'(cpu_err),  32'(vecs[i].e_err));
      chk($sformatf("v%0d_we", i),   32'(ram_we),   32'(vecs[i].e_we));
      chk($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
      to_drive();
    end

    // Pixel fetch at row 8, column 4: byte FF shows as white for four cycles.
    drive(1'b0, 4, 8, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    to_sample();
    chk("pix_addr", 32'(ram_addr), 32'd321);
    to_drive();
    drive(1'b0, 5, 8, 1'b0, 1'b0, 0, 8'h00, 8'hFF);
    to_drive();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 6 + k, 8, 1'b0, 1'b0, 0, 8'h00, 8'h00);
      to_sample();
      chk($sformatf("pix_red%0d", k),   32'(redOut),   32'd7);
      chk($sformatf("pix_green%0d", k), 32'(greenOut), 32'd7);
      chk($sformatf("pix_blue%0d", k),  32'(blueOut),  32'd3);
      to_drive();
    end
    drive(1'b0, 10, 8, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    to_sample();
    chk("pix_reload", 32'({redOut, greenOut, blueOut}), 32'd0);
    to_drive();

    // Reads at the last valid address and the first invalid one.
    drive(1'b0, 0, 500, 1'b1, 1'b0, 19199, 8'h00, 8'h00);
    to_sample();
    chk("rd_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_we",  32'(ram_we),  32'd0);
    chk("rd_err", 32'(cpu_err), 32'd0);
    to_drive();
    drive(1'b0, 1, 500, 1'b0, 1'b0, 0, 8'h00, 8'h5A);
    to_sample();
    chk("rd_rvalid", 32'(cpu_rvalid), 32'(READ_EN));
    chk("rd_rdata",  32'(cpu_rdata),  READ_EN ? 32'h5A : 32'h0);
    to_drive();
    drive(1'b0, 2, 500, 1'b1, 1'b0, 19200, 8'h00, 8'h00);
    to_sample();
    chk("rderr_gnt", 32'(cpu_gnt), 32'd1);
    chk("rderr_err", 32'(cpu_err), 32'd1);
    to_drive();
    drive(1'b0, 3, 500, 1'b0, 1'b0, 0, 8'h00, 8'h77);
    to_sample();
    chk("rderr_rvalid", 32'(cpu_rvalid), 32'(READ_EN));
    chk("rderr_rdata",  32'(cpu_rdata),  32'h0);
    to_drive();

    // Reset right after a read grant swallows the response.
    drive(1'b0, 0, 500, 1'b1, 1'b0, 10, 8'h00, 8'h00);
    to_sample();
    chk("rst_rd_gnt", 32'(cpu_gnt), 32'd1);
    to_drive();
    drive(1'b1, 1, 500, 1'b0, 1'b0, 0, 8'h00, 8'h99);
    to_sample();
    chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_rdata",  32'(cpu_rdata),  32'd0);
    chk("rst_addr",   32'(ram_addr),   32'd0);
    to_drive();
    drive(1'b0, 2, 500, 1'b0, 1'b0, 0, 8'h00, 8'h99);
    to_sample();
    chk("post_rst_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("post_rst_addr",   32'(ram_addr),   32'd0);
    chk("post_rst_rdata",  32'(cpu_rdata),  32'd0);
    to_drive();

    // Random raster with random CPU traffic; the model checks every cycle.
    xi = 600; yi = 470; seen_gnt = 0;
    cpu_req = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      xi++;
      if (xi == 800) begin xi = 0; yi = (yi + 1) % 525; end
      if ($urandom_range(0, 49) == 0) begin
        xi = int'($urandom_range(0, 799));
        yi = int'($urandom_range(0, 524));
      end
      x_pos = 10'(xi);
      y_pos = 10'(yi);
      rst = ($urandom_range(0, 199) == 0);
      ram_rdata = 8'($urandom);
      if (seen_gnt || !cpu_req) begin
        cpu_req = ($urandom_range(0, 2) != 0);
        cpu_we  = 1'($urandom);
        cpu_wdata = 8'($urandom);
        case ($urandom_range(0, 9))
          0:       cpu_addr = 15'($urandom_range(19200, 32767));
          1:       cpu_addr = 15'($urandom_range(19199, 19200));
          default: cpu_addr = 15'($urandom_range(0, 19199));
        endcase
      end
      to_sample();
      seen_gnt = cpu_gnt;
      to_drive();
    end

    to_sample();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
